// File: rtl/seq_mult_add.sv
// Rebuilds a dividend D = Q*M + R from 4-bit divider results with a shift-add
// multiplier. It also flags operand sets that no 4-bit divider could have produced.
module seq_mult_add (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [3:0] Q,
   input  logic [3:0] M,
   input  logic [3:0] R,
   output logic [7:0] D,
   output logic       busy,
   output logic       done,
   output logic       range_err,
   output logic       rem_err
);

   typedef enum logic [1:0] {StIdle, StMul, StAdd} state_e;

   state_e     state_q;
   logic [1:0] cnt_q;
   logic [3:0] q_q;
   logic [3:0] m_q;
   logic [3:0] r_q;
   logic [7:0] acc_q;

   logic [7:0] addend;
   logic [7:0] sum;

   always_comb begin
      addend = {4'b0000, m_q} << cnt_q;
      sum    = acc_q + {4'b0000, r_q};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         q_q       <= '0;
         m_q       <= '0;
         r_q       <= '0;
         acc_q     <= '0;
         D         <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         range_err <= 1'b0;
         rem_err   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_q)
            StIdle: begin
               if (start) begin
                  q_q     <= Q;
                  m_q     <= M;
                  r_q     <= R;
                  acc_q   <= '0;
                  cnt_q   <= '0;
                  busy    <= 1'b1;
                  state_q <= StMul;
               end
            end
            StMul: begin
               // One partial product per bit of Q, LSB first
               if (q_q[0]) acc_q <= acc_q + addend;
               q_q   <= q_q >> 1;
               cnt_q <= cnt_q + 2'd1;
               if (cnt_q == 2'd3) state_q <= StAdd;
            end
            StAdd: begin
               D         <= sum;
               range_err <= (sum > 8'd127);
               rem_err   <= (m_q == 4'd0) || (r_q >= m_q);
               done      <= 1'b1;
               busy      <= 1'b0;
               state_q   <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_mult_add.sv
// Self-checking bench for seq_mult_add. It runs a table of directed vectors, some
// hand-written timing sequences, and random operations checked against an arithmetic model.
module tb_seq_mult_add;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [3:0] Q;
   logic [3:0] M;
   logic [3:0] R;
   logic [7:0] D;
   logic       busy;
   logic       done;
   logic       range_err;
   logic       rem_err;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [3:0] q;
      logic [3:0] m;
      logic [3:0] r;
      logic [7:0] d;
      logic       rng;
      logic       rem;
   } vec_t;

   vec_t vecs[9];

   seq_mult_add dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .Q         (Q),
      .M         (M),
      .R         (R),
      .D         (D),
      .busy      (busy),
      .done      (done),
      .range_err (range_err),
      .rem_err   (rem_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Launch one operation and wait for done. On return the bench sits at the negedge
   // where done is high. With noise set, operands and start are scrambled while busy.
   task automatic do_op(input logic [3:0] q, input logic [3:0] m, input logic [3:0] r,
                        input bit noise, output logic [7:0] d, output logic rng,
                        output logic rem, output int lat, output bit busy_ok);
      @(negedge clk);
      Q = q; M = m; R = r; start = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      busy_ok = (busy === 1'b1);
      lat     = 0;
      while (done !== 1'b1 && lat < 20) begin
         if (noise) begin
            Q = 4'($urandom); M = 4'($urandom); R = 4'($urandom);
            start = 1'($urandom);
         end
         @(negedge clk);
         lat++;
         if (done !== 1'b1 && busy !== 1'b1) busy_ok = 1'b0;
      end
      start = 1'b0;
      d   = D;
      rng = range_err;
      rem = rem_err;
      if (busy !== 1'b0) busy_ok = 1'b0;
   endtask

   initial begin
      logic [7:0] d;
      logic       rng;
      logic       rem;
      int         lat;
      bit         busy_ok;
      int         exp_d;
      int         n_done;
      logic [3:0] rq;
      logic [3:0] rm;
      logic [3:0] rr;

      vecs[0] = '{q: 4'd3,  m: 4'd2,  r: 4'd1,  d: 8'd7,   rng: 1'b0, rem: 1'b0};
      vecs[1] = '{q: 4'd2,  m: 4'd5,  r: 4'd2,  d: 8'd12,  rng: 1'b0, rem: 1'b0};
      vecs[2] = '{q: 4'd15, m: 4'd15, r: 4'd15, d: 8'd240, rng: 1'b1, rem: 1'b1};
      vecs[3] = '{q: 4'd3,  m: 4'd2,  r: 4'd2,  d: 8'd8,   rng: 1'b0, rem: 1'b1};
      vecs[4] = '{q: 4'd4,  m: 4'd0,  r: 4'd3,  d: 8'd3,   rng: 1'b0, rem: 1'b1};
      vecs[5] = '{q: 4'd0,  m: 4'd7,  r: 4'd6,  d: 8'd6,   rng: 1'b0, rem: 1'b0};
      vecs[6] = '{q: 4'd9,  m: 4'd14, r: 4'd13, d: 8'd139, rng: 1'b1, rem: 1'b0};
      vecs[7] = '{q: 4'd8,  m: 4'd15, r: 4'd0,  d: 8'd120, rng: 1'b0, rem: 1'b0};
      vecs[8] = '{q: 4'd0,  m: 4'd0,  r: 4'd0,  d: 8'd0,   rng: 1'b0, rem: 1'b1};

      rst_n = 1'b0; start = 1'b0; Q = '0; M = '0; R = '0;
      #12;
      check("reset_D", D, 0);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_range_err", range_err, 0);
      check("reset_rem_err", rem_err, 0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         do_op(vecs[i].q, vecs[i].m, vecs[i].r, 1'b0, d, rng, rem, lat, busy_ok);
         check($sformatf("vec%0d_D", i), d, vecs[i].d);
         check($sformatf("vec%0d_range_err", i), rng, vecs[i].rng);
         check($sformatf("vec%0d_rem_err", i), rem, vecs[i].rem);
         check($sformatf("vec%0d_latency", i), lat, 5);
         check($sformatf("vec%0d_busy", i), busy_ok, 1);
         @(negedge clk);
         check($sformatf("vec%0d_done_width", i), done, 0);
         check($sformatf("vec%0d_D_hold", i), D, vecs[i].d);
      end

      // Back-to-back: second start presented in the done cycle
      do_op(4'd2, 4'd5, 4'd2, 1'b0, d, rng, rem, lat, busy_ok);
      check("b2b_first_D", d, 12);
      Q = 4'd2; M = 4'd4; R = 4'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("b2b_accept_busy", busy, 1);
      lat = 0;
      while (done !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check("b2b_latency", lat, 5);
      check("b2b_second_D", D, 9);
      check("b2b_second_rem_err", rem_err, 0);

      // Operands changed and start re-pulsed mid-operation must be ignored
      @(negedge clk);
      Q = 4'd3; M = 4'd2; R = 4'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      Q = 4'd15; M = 4'd15; R = 4'd15; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 2;
      while (done !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check("ignore_latency", lat, 5);
      check("ignore_D", D, 6);
      check("ignore_rem_err", rem_err, 0);
      n_done = 0;
      repeat (8) begin
         @(negedge clk);
         if (done === 1'b1) n_done++;
      end
      check("ignore_single_done", n_done, 0);

      // Asynchronous reset between E2 and E3 aborts the operation
      Q = 4'd15; M = 4'd1; R = 4'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort_D", D, 0);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_range_err", range_err, 0);
      check("abort_rem_err", rem_err, 0);
      start = 1'b1;
      n_done = 0;
      repeat (3) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) n_done++;
      end
      check("start_ignored_in_reset", n_done, 0);
      rst_n = 1'b1; start = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (done === 1'b1) n_done++;
      end
      check("no_done_after_abort", n_done, 0);
      do_op(4'd1, 4'd1, 4'd0, 1'b0, d, rng, rem, lat, busy_ok);
      check("restart_D", d, 1);
      check("restart_latency", lat, 5);
      check("restart_rem_err", rem, 0);

      // Random operations against the arithmetic model, with bus noise while busy
      for (int k = 0; k < 40; k++) begin
         rq = 4'($urandom); rm = 4'($urandom); rr = 4'($urandom);
         if (k % 4 == 0) rr = 4'($urandom_range(0, 15));
         do_op(rq, rm, rr, 1'b1, d, rng, rem, lat, busy_ok);
         exp_d = int'(rq) * int'(rm) + int'(rr);
         check($sformatf("rand%0d_D(q=%0d,m=%0d,r=%0d)", k, rq, rm, rr), d, exp_d);
         check($sformatf("rand%0d_range_err", k), rng, (exp_d > 127) ? 1 : 0);
         check($sformatf("rand%0d_rem_err", k), rem, (rm == 0 || rr >= rm) ? 1 : 0);
         check($sformatf("rand%0d_latency", k), lat, 5);
         check($sformatf("rand%0d_busy", k), busy_ok, 1);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
